// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial wide adder: FSM state encoding and
// the width of the adder slice that processes one nibble per clock.
// Optional feature macro: NIBBLE_ADDER_OVF_EN (no effect inside this package).
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
// Operand/result handshake bundle for nibble_serial_adder.
//   in_valid/in_ready   operand handshake (a, b, ci)
//   out_valid/out_ready result handshake (s, co, ovf)
//   ovf                 signed overflow, only when NIBBLE_ADDER_OVF_EN is defined
// Modports: master drives operands and out_ready; slave is the adder.
interface nibble_serial_adder_if
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
);
   localparam int W = NIBBLE_W * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         co;
`ifdef NIBBLE_ADDER_OVF_EN
   logic         ovf;

   modport master (output in_valid, a, b, ci, out_ready,
                   input  in_ready, out_valid, s, co, ovf);
   modport slave  (input  in_valid, a, b, ci, out_ready,
                   output in_ready, out_valid, s, co, ovf);
`else
   modport master (output in_valid, a, b, ci, out_ready,
                   input  in_ready, out_valid, s, co);
   modport slave  (input  in_valid, a, b, ci, out_ready,
                   output in_ready, out_valid, s, co);
`endif

endinterface

// File: rtl/nibble_serial_adder_st_sum4.sv
// st_sum4
// 4-bit structural ripple-carry adder slice.
//   a, b  4-bit addends
//   ci    carry in
//   s     4-bit sum
//   co    carry out
module st_sum4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Adds two NIBBLES*4-bit operands one nibble per clock through a single
// st_sum4 slice; the slice carry is registered and fed back for the next nibble.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   nibble_serial_adder_if.slave (operand and result handshakes)
// Optional feature macro: NIBBLE_ADDER_OVF_EN adds the signed-overflow flag.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ADD   | one nibble per cycle through the slice, LSB first
// DONE  | out_valid high, result held until out_ready
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t               state, state_nxt;
   logic [W-1:0]         a_sr, b_sr, s_reg, s_shift;
   logic                 carry;
   logic [IDX_W-1:0]     idx;
   logic [NIBBLE_W-1:0]  sum4;
   logic                 co4;
   logic                 last;
`ifdef NIBBLE_ADDER_OVF_EN
   logic                 a_msb, b_msb, ovf_reg;
`endif

   st_sum4 u_slice (
      .a  (a_sr[NIBBLE_W-1:0]),
      .b  (b_sr[NIBBLE_W-1:0]),
      .ci (carry),
      .s  (sum4),
      .co (co4)
   );

   assign last = (idx == LAST_IDX);

   // New sum nibble enters at the top so after NIBBLES shifts the first
   // nibble has walked down to bits [3:0].
   if (NIBBLES == 1) begin : g_one
      assign s_shift = sum4;
   end else begin : g_many
      assign s_shift = {sum4, s_reg[W-1:NIBBLE_W]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = ADD;
         ADD:     if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         s_reg   <= '0;
         carry   <= 1'b0;
         idx     <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         ovf_reg <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_sr    <= bus.a;
               b_sr    <= bus.b;
               carry   <= bus.ci;
               idx     <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
               a_msb   <= bus.a[W-1];
               b_msb   <= bus.b[W-1];
               ovf_reg <= 1'b0;
`endif
            end
            ADD: begin
               s_reg <= s_shift;
               carry <= co4;
               a_sr  <= a_sr >> NIBBLE_W;
               b_sr  <= b_sr >> NIBBLE_W;
               idx   <= idx + 1'b1;
`ifdef NIBBLE_ADDER_OVF_EN
               // sum4[3] becomes s[W-1] on this final shift
               if (last) ovf_reg <= (a_msb == b_msb) && (sum4[NIBBLE_W-1] != a_msb);
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.s         = s_reg;
   assign bus.co        = carry;
`ifdef NIBBLE_ADDER_OVF_EN
   assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder: a NIBBLES=4 and a NIBBLES=1
// instance share clock and reset; results are compared against plain
// wide-integer addition. Honors NIBBLE_ADDER_OVF_EN for the ovf output.
module tb_nibble_serial_adder;

   localparam int N4 = 4;
   localparam int W4 = 16;
   localparam int N1 = 1;
   localparam int W1 = 4;

   logic clk = 1'b0;
   logic rst;

   int n_cmp = 0;
   int n_err = 0;

   logic [W4-1:0] exp_s4;
   logic          exp_co4;
   logic          exp_ovf4;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(N4)) bus4 ();
   nibble_serial_adder_if #(.NIBBLES(N1)) bus1 ();

   nibble_serial_adder #(.NIBBLES(N4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   nibble_serial_adder #(.NIBBLES(N1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Accept one operand set on the 16-bit instance and wait for DONE.
   task automatic txn4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic ci);
      logic [W4:0] full;
      int lat;
      full     = {1'b0, a} + {1'b0, b} + {{W4{1'b0}}, ci};
      exp_s4   = full[W4-1:0];
      exp_co4  = full[W4];
      exp_ovf4 = (a[W4-1] == b[W4-1]) && (full[W4-1] != a[W4-1]);
      @(negedge clk);
      bus4.a = a; bus4.b = b; bus4.ci = ci; bus4.in_valid = 1'b1;
      chk("in_ready_idle", bus4.in_ready, 1);
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      chk("in_ready_busy", bus4.in_ready, 0);
      lat = 0;
      while (!bus4.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency4", lat, N4);
      chk("sum4", bus4.s, exp_s4);
      chk("co4", bus4.co, exp_co4);
`ifdef NIBBLE_ADDER_OVF_EN
      chk("ovf4", bus4.ovf, exp_ovf4);
`endif
   endtask

   task automatic release4();
      @(negedge clk);
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
      chk("rel_out_valid", bus4.out_valid, 0);
      chk("rel_in_ready", bus4.in_ready, 1);
      chk("rel_s_kept", bus4.s, exp_s4);
   endtask

   task automatic txn1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic ci);
      logic [W1:0] full;
      int lat;
      full = {1'b0, a} + {1'b0, b} + {{W1{1'b0}}, ci};
      @(negedge clk);
      bus1.a = a; bus1.b = b; bus1.ci = ci; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency1", lat, N1);
      chk("sum1", bus1.s, full[W1-1:0]);
      chk("co1", bus1.co, full[W1]);
`ifdef NIBBLE_ADDER_OVF_EN
      chk("ovf1", bus1.ovf, (a[W1-1] == b[W1-1]) && (full[W1-1] != a[W1-1]));
`endif
      @(negedge clk);
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      chk("rel1_in_ready", bus1.in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
      exp_s4 = '0; exp_co4 = 1'b0; exp_ovf4 = 1'b0;
      #3;
      chk("rst_in_ready", bus4.in_ready, 1);
      chk("rst_out_valid", bus4.out_valid, 0);
      chk("rst_s", bus4.s, 0);
      chk("rst_co", bus4.co, 0);
`ifdef NIBBLE_ADDER_OVF_EN
      chk("rst_ovf", bus4.ovf, 0);
`endif
      chk("rst1_in_ready", bus1.in_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      txn4(16'h00FF, 16'h0001, 1'b0); release4();
      txn4(16'hFFFF, 16'h0000, 1'b1); release4();
      txn4(16'h7FFF, 16'h0001, 1'b0); release4();

      // back-pressure: result held, new operands ignored
      txn4(16'hA5C3, 16'h5E7D, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus4.in_valid = i[0];
         bus4.a = 16'($urandom);
         @(posedge clk); #1;
         chk("bp_s", bus4.s, exp_s4);
         chk("bp_co", bus4.co, exp_co4);
         chk("bp_in_ready", bus4.in_ready, 0);
         chk("bp_out_valid", bus4.out_valid, 1);
      end
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b0;
      chk("done_exit_in_ready", bus4.in_ready, 1);
      chk("done_exit_out_valid", bus4.out_valid, 0);
      @(posedge clk); #1;
      chk("no_accept_from_done", bus4.in_ready, 1);

      // reset two cycles into ADD
      @(negedge clk);
      bus4.a = 16'h9999; bus4.b = 16'h8888; bus4.ci = 1'b1; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", bus4.out_valid, 0);
      chk("abort_s", bus4.s, 0);
      chk("abort_co", bus4.co, 0);
      chk("abort_in_ready", bus4.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      txn4(16'h1234, 16'h4321, 1'b0); release4();

      for (int i = 0; i < 25; i++) begin
         txn4(16'($urandom), 16'($urandom), 1'($urandom));
         release4();
      end

      txn1(4'hF, 4'h1, 1'b1);
      for (int i = 0; i < 10; i++) txn1(4'($urandom), 4'($urandom), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
